conv_layer_ctrl: RTL

- Generic sequencer for one convolution layer of the LeNet-5 datapath.
- Loads weights and biases for all output channels, primes a K-column input window, then sweeps every output position row-by-row within each column, strobing the MAC/pool array.
- Drains the downstream pipeline, then pulses done.
- Parametrised in image size, kernel size, channel count and memory read latency; successor to the fixed 32x32/5x5/6-channel front-layer controller, adding abort and backpressure.

---
 rtl/conv_layer_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_ctrl.sv
// Sequencer for one convolution layer: weight/bias load, K-column window fill,
// column-major output sweep, pipeline drain. Optional macro CONV_BACKPRESSURE_EN.
module conv_layer_ctrl #(
    parameter int IN_W     = 32,
    parameter int IN_H     = 32,
    parameter int K        = 5,
    parameter int OUT_CH   = 6,
    parameter int READ_LAT = 2,
    parameter int PIPE_LAT = 6,
    parameter int W_AW     = 8,
    parameter int IN_AW    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      mac_rdy,
    output logic                      w_rd_en,
    output logic [W_AW-1:0]           w_addr,
    output logic                      w_load_vld,
    output logic [$clog2(K*K+1)-1:0]  w_load_idx,
    output logic [$clog2(OUT_CH)-1:0] w_load_ch,
    output logic                      in_rd_en,
    output logic [IN_AW-1:0]          in_addr,
    output logic                      col_shift,
    output logic                      mac_vld,
    output logic [$clog2(IN_H)-1:0]   out_row,
    output logic [$clog2(IN_W)-1:0]   out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);
    localparam int OUT_W = IN_W - K + 1;
    localparam int OUT_H = IN_H - K + 1;
    localparam int KK1   = K * K + 1;
    localparam int N_W   = OUT_CH * KK1;
    localparam int WCW   = $clog2(N_W + 1);
    localparam int ICW   = $clog2(IN_W + 1);
    localparam int KCW   = $clog2(K + 1);
    localparam int DCW   = $clog2(PIPE_LAT + 1);
    localparam int IDX_W = $clog2(KK1);
    localparam int CH_W  = $clog2(OUT_CH);
    localparam int ROW_W = $clog2(IN_H);
    localparam int COL_W = $clog2(IN_W);

    localparam logic [WCW-1:0]   W_END     = WCW'(N_W);
    localparam logic [ICW-1:0]   FILL_END  = ICW'(K);
    localparam logic [KCW-1:0]   SHIFT_LST = KCW'(K - 1);
    localparam logic [DCW-1:0]   DRAIN_LST = DCW'(PIPE_LAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(K * K);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(OUT_CH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(OUT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_FILL, S_CALC, S_SHIFT, S_DRAIN, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [WCW-1:0]    w_cnt_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [ICW-1:0]    in_cnt_reg;
    logic [KCW-1:0]    shift_cnt_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [COL_W-1:0]  col_reg;
    logic [DCW-1:0]    drain_reg;

    logic adv, last_row, last_col, w_last_ret, pipe_clr;

`ifdef CONV_BACKPRESSURE_EN
    assign adv = mac_rdy;
`else
    logic unused_mac_rdy;
    assign unused_mac_rdy = mac_rdy;
    assign adv = 1'b1;
`endif

    assign last_row   = (row_reg == ROW_LAST);
    assign last_col   = (col_reg == COL_LAST);
    assign pipe_clr   = rst | abort;
    assign w_last_ret = w_load_vld && (w_load_ch == CH_LAST) && (w_load_idx == IDX_LAST);

    // Read-latency pipes: tags travel with each read so data and metadata arrive together.
    generate
        for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_rd_pipe
            logic             w_vld_reg, w_vld_src;
            logic [IDX_W-1:0] w_idx_reg, w_idx_src;
            logic [CH_W-1:0]  w_ch_reg, w_ch_src;
            logic             in_vld_reg, in_vld_src;
            if (gi == 0) begin : g_src
                assign w_vld_src  = w_rd_en;
                assign w_idx_src  = w_rd_en ? idx_reg : '0;
                assign w_ch_src   = w_rd_en ? ch_reg : '0;
                assign in_vld_src = in_rd_en;
            end else begin : g_src
                assign w_vld_src  = g_rd_pipe[gi-1].w_vld_reg;
                assign w_idx_src  = g_rd_pipe[gi-1].w_idx_reg;
                assign w_ch_src   = g_rd_pipe[gi-1].w_ch_reg;
                assign in_vld_src = g_rd_pipe[gi-1].in_vld_reg;
            end
            always_ff @(posedge clk) begin
                if (pipe_clr) begin
                    w_vld_reg  <= 1'b0;
                    w_idx_reg  <= '0;
                    w_ch_reg   <= '0;
                    in_vld_reg <= 1'b0;
                end else begin
                    w_vld_reg  <= w_vld_src;
                    w_idx_reg  <= w_idx_src;
                    w_ch_reg   <= w_ch_src;
                    in_vld_reg <= in_vld_src;
                end
            end
        end
    endgenerate

    assign w_load_vld = g_rd_pipe[READ_LAT-1].w_vld_reg;
    assign w_load_idx = g_rd_pipe[READ_LAT-1].w_idx_reg;
    assign w_load_ch  = g_rd_pipe[READ_LAT-1].w_ch_reg;
    assign col_shift  = g_rd_pipe[READ_LAT-1].in_vld_reg;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        w_rd_en    = 1'b0;
        in_rd_en   = 1'b0;
        mac_vld    = 1'b0;
        out_last   = 1'b0;
        busy       = (state_reg != S_IDLE);
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LOAD_W;
            end
            S_LOAD_W: begin
                w_rd_en = (w_cnt_reg != W_END);
                if (w_last_ret) state_next = S_FILL;
            end
            S_FILL: begin
                in_rd_en = (in_cnt_reg < FILL_END);
                if (col_shift && shift_cnt_reg == SHIFT_LST) state_next = S_CALC;
            end
            S_CALC: begin
                mac_vld  = 1'b1;
                out_last = last_row && last_col;
                // The next column is fetched on the accepted bottom-row beat.
                in_rd_en = adv && last_row && !last_col;
                if (adv && last_row) state_next = last_col ? S_DRAIN : S_SHIFT;
            end
            S_SHIFT: begin
                if (col_shift) state_next = S_CALC;
            end
            S_DRAIN: begin
                if (drain_reg == DRAIN_LST) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || abort || state_reg == S_IDLE) begin
            w_cnt_reg     <= '0;
            idx_reg       <= '0;
            ch_reg        <= '0;
            in_cnt_reg    <= '0;
            shift_cnt_reg <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            drain_reg     <= '0;
        end else begin
            if (w_rd_en) begin
                w_cnt_reg <= w_cnt_reg + 1'b1;
                if (idx_reg == IDX_LAST) begin
                    idx_reg <= '0;
                    if (ch_reg != CH_LAST) ch_reg <= ch_reg + 1'b1;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
            if (in_rd_en) in_cnt_reg <= in_cnt_reg + 1'b1;
            if (state_reg == S_FILL && col_shift) shift_cnt_reg <= shift_cnt_reg + 1'b1;
            if (state_reg == S_CALC && adv && !last_row) row_reg <= row_reg + 1'b1;
            if (state_reg == S_SHIFT && col_shift) begin
                row_reg <= '0;
                col_reg <= col_reg + 1'b1;
            end
            if (state_reg == S_DRAIN) drain_reg <= drain_reg + 1'b1;
        end
    end

    assign w_addr  = W_AW'(w_cnt_reg);
    assign in_addr = IN_AW'(in_cnt_reg);
    assign out_row = row_reg;
    assign out_col = col_reg;

endmodule
